// File: rtl/mul_arbiter_if.sv
// Bus bundle between the requester cores, the shared multiplier and mul_arbiter.
// slave: the arbiter's view. master: the requesters' and multiplier's view.
interface mul_arbiter_if #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned DATA_LENGTH = 64
);
  localparam int unsigned ID_W = $clog2(NUM_REQ);

  // Control
  logic                             enable;
  logic                             busy;
  // Requester side
  logic [NUM_REQ-1:0]               req_valid;
  logic [NUM_REQ-1:0]               req_ready;
  logic [NUM_REQ*DATA_LENGTH-1:0]   req_a;
  logic [NUM_REQ*DATA_LENGTH-1:0]   req_b;
  logic [NUM_REQ-1:0]               resp_valid;
  logic [ID_W-1:0]                  resp_id;
  logic [2*DATA_LENGTH-1:0]         resp_data;
  // Multiplier side
  logic [DATA_LENGTH-1:0]           mul_a;
  logic [DATA_LENGTH-1:0]           mul_b;
  logic                             mul_start;
  logic [2*DATA_LENGTH-1:0]         mul_res;

  modport slave (
    input  enable, req_valid, req_a, req_b, mul_res,
    output busy, req_ready, resp_valid, resp_id, resp_data, mul_a, mul_b, mul_start
  );

  modport master (
    output enable, req_valid, req_a, req_b, mul_res,
    input  busy, req_ready, resp_valid, resp_id, resp_data, mul_a, mul_b, mul_start
  );
endinterface

// File: rtl/mul_arbiter.sv
// Round-robin arbiter sharing one fully pipelined multiplier among NUM_REQ requesters.
// A tag pipeline of MUL_LATENCY+1 {valid, id} stages routes each product back to its owner;
// accept-to-response latency is MUL_LATENCY+2 cycles.
// Optional statistics counters are built when MUL_ARB_STATS_EN is defined; otherwise the
// statistics ports are tied to zero.
module mul_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned DATA_LENGTH = 64,
  parameter int unsigned MUL_LATENCY = 18
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  mul_arbiter_if.slave           bus,
  output logic [NUM_REQ*32-1:0]  issue_cnt_o,
  output logic [31:0]            conflict_cnt_o
);

  localparam int unsigned ID_W  = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(MUL_LATENCY + 3);
  localparam int unsigned LAST  = MUL_LATENCY;

  logic [ID_W-1:0]          rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0]       grant;
  logic [ID_W-1:0]          grant_idx;
  logic [ID_W-1:0]          scan_idx;
  logic                     accept;
  logic [DATA_LENGTH-1:0]   sel_a, sel_b;

  logic [DATA_LENGTH-1:0]   mul_a_q, mul_b_q;
  logic                     mul_start_q;

  logic                     tag_vld_q [MUL_LATENCY+1];
  logic [ID_W-1:0]          tag_id_q  [MUL_LATENCY+1];

  logic [NUM_REQ-1:0]       resp_valid_q;
  logic [ID_W-1:0]          resp_id_q;
  logic [2*DATA_LENGTH-1:0] resp_data_q;

  logic [CNT_W-1:0]         inflight_q, inflight_d;
  logic                     busy_q;

  // Round-robin search starting at rr_ptr; first valid requester wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    accept    = 1'b0;
    scan_idx  = '0;
    if (bus.enable) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        scan_idx = ID_W'((32'(rr_ptr_q) + i) % NUM_REQ);
        if (!accept && bus.req_valid[scan_idx]) begin
          accept          = 1'b1;
          grant[scan_idx] = 1'b1;
          grant_idx       = scan_idx;
        end
      end
    end
  end

  assign bus.req_ready = grant;
  assign sel_a = bus.req_a[32'(grant_idx)*DATA_LENGTH +: DATA_LENGTH];
  assign sel_b = bus.req_b[32'(grant_idx)*DATA_LENGTH +: DATA_LENGTH];

  // Pointer moves just past the winner; unchanged when nothing is accepted.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (accept) begin
      rr_ptr_d = (32'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + ID_W'(1);
    end
  end

  // In-flight count: +1 per accept, -1 per delivered response.
  always_comb begin
    inflight_d = inflight_q;
    if (accept && !(|resp_valid_q)) begin
      inflight_d = inflight_q + CNT_W'(1);
    end else if (!accept && (|resp_valid_q)) begin
      inflight_d = inflight_q - CNT_W'(1);
    end
  end

  // Arbiter state, issue registers and busy flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q    <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      mul_start_q <= 1'b0;
      inflight_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      mul_start_q <= accept;
      if (accept) begin
        mul_a_q <= sel_a;
        mul_b_q <= sel_b;
      end
      inflight_q  <= inflight_d;
      busy_q      <= (inflight_d != '0);
    end
  end

  // Tag pipeline shifts every cycle, independent of enable, so drain completes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i <= LAST; i++) begin
        tag_vld_q[i] <= 1'b0;
        tag_id_q[i]  <= '0;
      end
    end else begin
      tag_vld_q[0] <= accept;
      tag_id_q[0]  <= grant_idx;
      for (int unsigned i = 1; i <= LAST; i++) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_id_q[i]  <= tag_id_q[i-1];
      end
    end
  end

  // Capture the product when the matching tag reaches the end; id/data hold otherwise.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      resp_valid_q <= '0;
      resp_id_q    <= '0;
      resp_data_q  <= '0;
    end else begin
      resp_valid_q <= '0;
      if (tag_vld_q[LAST]) begin
        resp_valid_q <= NUM_REQ'(1) << tag_id_q[LAST];
        resp_id_q    <= tag_id_q[LAST];
        resp_data_q  <= bus.mul_res;
      end
    end
  end

  assign bus.mul_a      = mul_a_q;
  assign bus.mul_b      = mul_b_q;
  assign bus.mul_start  = mul_start_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_id    = resp_id_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.busy       = busy_q;

`ifdef MUL_ARB_STATS_EN
  logic [NUM_REQ-1:0][31:0] issue_cnt_q;
  logic [31:0]              conflict_cnt_q;
  logic                     multi_valid;

  // More than one bit set: clearing the lowest set bit leaves something.
  assign multi_valid = |(bus.req_valid & (bus.req_valid - NUM_REQ'(1)));

  // Saturating per-requester issue counters and conflict counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      issue_cnt_q    <= '0;
      conflict_cnt_q <= '0;
    end else begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        if (grant[k] && (issue_cnt_q[k] != '1)) begin
          issue_cnt_q[k] <= issue_cnt_q[k] + 32'd1;
        end
      end
      if (bus.enable && multi_valid && (conflict_cnt_q != '1)) begin
        conflict_cnt_q <= conflict_cnt_q + 32'd1;
      end
    end
  end

  assign issue_cnt_o    = issue_cnt_q;
  assign conflict_cnt_o = conflict_cnt_q;
`else
  assign issue_cnt_o    = '0;
  assign conflict_cnt_o = '0;
`endif

endmodule

// File: tb/tb_mul_arbiter.sv
// Directed bench for mul_arbiter with a behavioural pipelined multiplier (latency ML).
module tb_mul_arbiter;
  localparam int unsigned NR = 4;
  localparam int unsigned DL = 64;
  localparam int unsigned ML = 18;

  logic clk = 1'b0;
  logic rst_n;
  logic [NR*32-1:0] issue_cnt;
  logic [31:0]      conflict_cnt;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mul_arbiter_if #(.NUM_REQ(NR), .DATA_LENGTH(DL)) bus ();

  mul_arbiter #(.NUM_REQ(NR), .DATA_LENGTH(DL), .MUL_LATENCY(ML)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .bus            (bus),
    .issue_cnt_o    (issue_cnt),
    .conflict_cnt_o (conflict_cnt)
  );

  // Behavioural multiplier: samples operands every edge, product appears ML cycles later.
  logic [2*DL-1:0] mpipe [ML];
  always @(posedge clk) begin
    mpipe[0] <= bus.mul_a * bus.mul_b;
    for (int i = 1; i < ML; i++) mpipe[i] <= mpipe[i-1];
  end
  assign bus.mul_res = mpipe[ML-1];

  logic [63:0]  ta [NR];
  logic [63:0]  tb [NR];
  logic [127:0] tp [NR];

  function automatic logic [3:0] onehot(int k);
    logic [3:0] one;
    one = 4'b0001;
    return one << k;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset ends 1 time unit after an edge; the caller is then in cycle 0.
  task automatic do_reset();
    bus.enable    = 1'b1;
    bus.req_valid = '0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    bus.enable    = 1'b1;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    rst_n = 1'b0;
    #3;
    checks++; if (bus.mul_start !== 1'b0) begin errors++; $display("FAIL rst_mul_start got=%b exp=0", bus.mul_start); end
    checks++; if (bus.mul_a !== 64'd0 || bus.mul_b !== 64'd0) begin errors++; $display("FAIL rst_mul_ops got=%h/%h exp=0", bus.mul_a, bus.mul_b); end
    checks++; if (bus.resp_valid !== 4'b0) begin errors++; $display("FAIL rst_resp_valid got=%b exp=0", bus.resp_valid); end
    checks++; if (bus.resp_id !== 2'd0) begin errors++; $display("FAIL rst_resp_id got=%0d exp=0", bus.resp_id); end
    checks++; if (bus.resp_data !== 128'd0) begin errors++; $display("FAIL rst_resp_data got=%h exp=0", bus.resp_data); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", bus.busy); end
    checks++; if (issue_cnt !== '0 || conflict_cnt !== 32'd0) begin errors++; $display("FAIL rst_stats got=%h/%h exp=0", issue_cnt, conflict_cnt); end
  endtask

  task automatic test_single();
    logic [127:0] exp_p;
    exp_p = 128'h1_FFFF_FFFF_FFFF_FFFE;
    do_reset();
    bus.req_a[2*DL +: DL] = 64'hFFFF_FFFF_FFFF_FFFF;
    bus.req_b[2*DL +: DL] = 64'd2;
    bus.req_valid = 4'b0100;
    #1;
    checks++; if (bus.req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready got=%b exp=0100", bus.req_ready); end
    step();
    bus.req_valid = '0;
    #1;
    checks++; if (bus.mul_start !== 1'b1) begin errors++; $display("FAIL single_start got=%b exp=1", bus.mul_start); end
    checks++; if (bus.mul_a !== 64'hFFFF_FFFF_FFFF_FFFF || bus.mul_b !== 64'd2) begin errors++; $display("FAIL single_ops got=%h/%h exp=ffffffffffffffff/2", bus.mul_a, bus.mul_b); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL single_busy1 got=%b exp=1", bus.busy); end
    for (int c = 2; c <= 21; c++) begin
      step();
      #1;
      checks++; if (bus.resp_valid !== ((c == 20) ? 4'b0100 : 4'b0000)) begin errors++; $display("FAIL single_resp_valid c=%0d got=%b", c, bus.resp_valid); end
      if (c == 2) begin
        checks++; if (bus.mul_start !== 1'b0) begin errors++; $display("FAIL single_start_pulse got=%b exp=0", bus.mul_start); end
      end
      if (c == 20) begin
        checks++; if (bus.resp_id !== 2'd2) begin errors++; $display("FAIL single_id got=%0d exp=2", bus.resp_id); end
        checks++; if (bus.resp_data !== exp_p) begin errors++; $display("FAIL single_data got=%h exp=%h", bus.resp_data, exp_p); end
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL single_busy20 got=%b exp=1", bus.busy); end
      end
      if (c == 21) begin
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL single_busy21 got=%b exp=0", bus.busy); end
        checks++; if (bus.resp_data !== exp_p || bus.resp_id !== 2'd2) begin errors++; $display("FAIL single_hold got=%h/%0d", bus.resp_data, bus.resp_id); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_r;
    int k;
    do_reset();
    for (int i = 0; i < NR; i++) begin
      ta[i] = 64'hFFFF_FFFF_FFFF_FFF0 + 64'(i);
      tb[i] = 64'h1_0000_0003 * 64'(i + 1);
      tp[i] = {64'd0, ta[i]} * {64'd0, tb[i]};
      bus.req_a[i*DL +: DL] = ta[i];
      bus.req_b[i*DL +: DL] = tb[i];
    end
    for (int c = 0; c <= 61; c++) begin
      bus.req_valid = (c < 40) ? 4'hF : 4'h0;
      #1;
      exp_r = (c < 40) ? onehot(c % 4) : 4'b0000;
      checks++; if (bus.req_ready !== exp_r) begin errors++; $display("FAIL b2b_ready c=%0d got=%b exp=%b", c, bus.req_ready, exp_r); end
      if (c >= 20 && c < 60) begin
        k = (c - 20) % 4;
        checks++;
        if (bus.resp_valid !== onehot(k) || bus.resp_id !== 2'(k) || bus.resp_data !== tp[k]) begin
          errors++;
          $display("FAIL b2b_resp c=%0d got=%b/%0d/%h exp=%b/%0d/%h", c, bus.resp_valid, bus.resp_id, bus.resp_data, onehot(k), k, tp[k]);
        end
      end else begin
        checks++; if (bus.resp_valid !== 4'b0) begin errors++; $display("FAIL b2b_idle c=%0d got=%b exp=0", c, bus.resp_valid); end
      end
      checks++; if (bus.busy !== (c >= 1 && c <= 59)) begin errors++; $display("FAIL b2b_busy c=%0d got=%b", c, bus.busy); end
      checks++; if (bus.mul_start !== (c >= 1 && c <= 40)) begin errors++; $display("FAIL b2b_start c=%0d got=%b", c, bus.mul_start); end
      step();
    end
  endtask

  task automatic test_fairness();
    logic [3:0] exp_r;
    do_reset();
    bus.req_valid = 4'b1001;
    for (int c = 0; c < 10; c++) begin
      #1;
      exp_r = (c % 2 == 0) ? 4'b0001 : 4'b1000;
      checks++; if (bus.req_ready !== exp_r) begin errors++; $display("FAIL fair_ready c=%0d got=%b exp=%b", c, bus.req_ready, exp_r); end
      step();
    end
    bus.req_valid = '0;
    #1;
`ifdef MUL_ARB_STATS_EN
    checks++; if (issue_cnt[0 +: 32] !== 32'd5 || issue_cnt[96 +: 32] !== 32'd5) begin errors++; $display("FAIL fair_issue03 got=%0d/%0d exp=5/5", issue_cnt[0 +: 32], issue_cnt[96 +: 32]); end
    checks++; if (issue_cnt[32 +: 64] !== 64'd0) begin errors++; $display("FAIL fair_issue12 got=%h exp=0", issue_cnt[32 +: 64]); end
    checks++; if (conflict_cnt !== 32'd10) begin errors++; $display("FAIL fair_conflict got=%0d exp=10", conflict_cnt); end
`else
    checks++; if (issue_cnt !== '0 || conflict_cnt !== 32'd0) begin errors++; $display("FAIL fair_stats_tied got=%h/%h exp=0", issue_cnt, conflict_cnt); end
`endif
    for (int c = 10; c <= 32; c++) begin
      exp_r = (c >= 20 && c <= 29) ? ((c % 2 == 0) ? 4'b0001 : 4'b1000) : 4'b0000;
      checks++; if (bus.resp_valid !== exp_r) begin errors++; $display("FAIL fair_resp c=%0d got=%b exp=%b", c, bus.resp_valid, exp_r); end
      step();
      #1;
    end
  endtask

  task automatic test_drain();
    logic [3:0] exp_r;
    int nresp;
    nresp = 0;
    do_reset();
    bus.req_valid = 4'hF;
    for (int c = 0; c <= 27; c++) begin
      bus.enable = (c < 5);
      #1;
      exp_r = (c < 5) ? onehot(c % 4) : 4'b0000;
      checks++; if (bus.req_ready !== exp_r) begin errors++; $display("FAIL drain_ready c=%0d got=%b exp=%b", c, bus.req_ready, exp_r); end
      exp_r = (c >= 20 && c <= 24) ? onehot((c - 20) % 4) : 4'b0000;
      checks++; if (bus.resp_valid !== exp_r) begin errors++; $display("FAIL drain_resp c=%0d got=%b exp=%b", c, bus.resp_valid, exp_r); end
      if (bus.resp_valid !== 4'b0) nresp++;
      checks++; if (bus.busy !== (c >= 1 && c <= 24)) begin errors++; $display("FAIL drain_busy c=%0d got=%b", c, bus.busy); end
      step();
    end
    checks++; if (nresp != 5) begin errors++; $display("FAIL drain_count got=%0d exp=5", nresp); end
    bus.enable = 1'b1;
    bus.req_valid = '0;
  endtask

  task automatic test_reset_midflight();
    logic [127:0] exp_p;
    do_reset();
    bus.req_valid = 4'hF;
    for (int c = 0; c < 8; c++) step();
    bus.req_valid = '0;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0 || bus.mul_start !== 1'b0 || bus.resp_valid !== 4'b0) begin errors++; $display("FAIL mid_rst_outs got=%b/%b/%b exp=0/0/0", bus.busy, bus.mul_start, bus.resp_valid); end
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 30; c++) begin
      #1;
      checks++; if (bus.resp_valid !== 4'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL mid_quiet c=%0d got=%b/%b exp=0/0", c, bus.resp_valid, bus.busy); end
      step();
    end
    bus.req_a[2*DL +: DL] = 64'h0000_0001_0000_0001;
    bus.req_b[2*DL +: DL] = 64'h0000_0000_FFFF_FFFF;
    exp_p = 128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF;
    bus.req_valid = 4'b0100;
    #1;
    checks++; if (bus.req_ready !== 4'b0100) begin errors++; $display("FAIL mid_new_ready got=%b exp=0100", bus.req_ready); end
    step();
    bus.req_valid = '0;
    for (int c = 1; c <= 20; c++) begin
      #1;
      checks++; if (bus.resp_valid !== ((c == 20) ? 4'b0100 : 4'b0000)) begin errors++; $display("FAIL mid_new_resp c=%0d got=%b", c, bus.resp_valid); end
      if (c == 20) begin
        checks++; if (bus.resp_data !== exp_p) begin errors++; $display("FAIL mid_new_data got=%h exp=%h", bus.resp_data, exp_p); end
      end
      step();
    end
  endtask

  task automatic test_withdrawal();
    logic [3:0] exp_r;
    do_reset();
    bus.req_valid = 4'b0011;
    #1;
    checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL wd_grant0 got=%b exp=0001", bus.req_ready); end
    step();
    bus.req_valid = 4'b0000;
    #1;
    checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL wd_none got=%b exp=0000", bus.req_ready); end
    step();
    // Pointer now at 1: between requesters 0 and 2, requester 2 wins.
    bus.req_valid = 4'b0101;
    #1;
    checks++; if (bus.req_ready !== 4'b0100) begin errors++; $display("FAIL wd_ptr got=%b exp=0100", bus.req_ready); end
    step();
    bus.req_valid = '0;
    for (int c = 3; c <= 30; c++) begin
      #1;
      exp_r = (c == 20) ? 4'b0001 : ((c == 22) ? 4'b0100 : 4'b0000);
      checks++; if (bus.resp_valid !== exp_r) begin errors++; $display("FAIL wd_resp c=%0d got=%b exp=%b", c, bus.resp_valid, exp_r); end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_fairness();
    test_drain();
    test_reset_midflight();
    test_withdrawal();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
